// File: rtl/pc.sv
// Program counter register: loads pc_in when enabled, holds on stall,
// asynchronous active-high reset to RESET_VAL, plus a word-misalignment flag.
module pc #(
    parameter int unsigned             PC_SIZE   = 32,
    parameter logic [PC_SIZE-1:0]      RESET_VAL = '0
) (
    input  logic               clk,
    input  logic               arst_n,
    input  logic               en_in,
    input  logic [PC_SIZE-1:0] pc_in,
    output logic [PC_SIZE-1:0] pc_out,
    output logic               misalign_out
);

    logic [PC_SIZE-1:0] r_pc;
    logic               w_misalign;

    // arst_n is active-high despite its name. The ternary lets an unknown
    // enable propagate X into the PC rather than silently holding.
    always_ff @(posedge clk or posedge arst_n) begin
        if (arst_n) begin
            r_pc <= RESET_VAL;
        end else begin
            r_pc <= en_in ? pc_in : r_pc;
        end
    end

    always_comb begin
        w_misalign = |r_pc[1:0];
    end

    assign pc_out       = r_pc;
    assign misalign_out = w_misalign;

endmodule

// File: tb/tb_pc.sv
// Self-checking bench for pc: directed scenarios followed by randomized
// load/stall/reset traffic compared against a behavioural PC model.
module tb_pc;

    localparam int unsigned        W    = 32;
    localparam logic [W-1:0]       RVAL = 32'h0000_0000;

    logic         clk;
    logic         arst_n;
    logic         en_in;
    logic [W-1:0] pc_in;
    logic [W-1:0] pc_out;
    logic         misalign_out;

    int unsigned  n_checks;
    int unsigned  n_pass;
    logic [W-1:0] m_pc;

    pc #(.PC_SIZE(W), .RESET_VAL(RVAL)) dut (
        .clk          (clk),
        .arst_n       (arst_n),
        .en_in        (en_in),
        .pc_in        (pc_in),
        .pc_out       (pc_out),
        .misalign_out (misalign_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic check_state(input string tag);
        logic [W-1:0] exp_mis;
        exp_mis = (m_pc % 4 != 0) ? 32'd1 : 32'd0;
        check({tag, ".pc"}, pc_out, m_pc);
        check({tag, ".mis"}, {31'd0, misalign_out}, exp_mis);
    endtask

    // Drive inputs, take one rising edge, update the model, check 1 unit later.
    task automatic edge_step(input logic en, input logic [W-1:0] nxt, input string tag);
        en_in = en;
        pc_in = nxt;
        @(posedge clk);
        if (arst_n)   m_pc = RVAL;
        else if (en)  m_pc = nxt;
        #1;
        check_state(tag);
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        arst_n   = 1'b0;
        en_in    = 1'b0;
        pc_in    = '0;
        m_pc     = RVAL;

        // Reset assert/hold: clock edges and enable must not disturb it.
        #2 arst_n = 1'b1;
        #1 check_state("rst_init");
        edge_step(1'b1, 32'h55, "rst_hold0");
        edge_step(1'b1, 32'hAB, "rst_hold1");
        arst_n = 1'b0;

        // Load 0x40, then assert reset mid-cycle with no clock edge.
        edge_step(1'b1, 32'h40, "load40");
        #2 arst_n = 1'b1;
        m_pc = RVAL;
        #1 check_state("async_rst");
        @(posedge clk);
        #1 check_state("rst_after_edge");
        arst_n = 1'b0;

        // Sequential fetch: PC+4 each cycle.
        for (int i = 0; i < 4; i++) edge_step(1'b1, m_pc + 32'd4, "seq");

        // Stall three cycles, then resume.
        for (int i = 0; i < 3; i++) edge_step(1'b0, 32'h14, "stall");
        edge_step(1'b1, 32'h14, "resume");

        // Branch, then misaligned target.
        edge_step(1'b1, 32'h100, "branch");
        edge_step(1'b1, 32'h2, "misalign");

        // Top of address space and wrapped successor.
        edge_step(1'b1, 32'hFFFF_FFFC, "top");
        edge_step(1'b1, 32'h0000_0000, "wrap");
        edge_step(1'b1, 32'hFFFF_FFFF, "allones");

        // Mid-cycle input wiggle must not reach pc_out.
        en_in = 1'b1;
        pc_in = 32'h1234_5678;
        #2 check_state("midcycle0");
        en_in = 1'b0;
        pc_in = 32'h0;
        #2 check_state("midcycle1");

        // Reset during a stall.
        edge_step(1'b0, 32'h99, "pre_stall_rst");
        arst_n = 1'b1;
        m_pc   = RVAL;
        #1 check_state("stall_rst");
        #1 arst_n = 1'b0;
        edge_step(1'b1, 32'h24, "post_stall_rst");

        // Reset coincident with an enabled load edge: reset wins.
        en_in = 1'b1;
        pc_in = 32'h80;
        @(posedge clk);
        arst_n = 1'b1;
        m_pc   = RVAL;
        #1 check_state("rst_vs_load");
        #1 arst_n = 1'b0;
        edge_step(1'b0, 32'h80, "rst_vs_load_hold");

        // Randomized traffic.
        for (int i = 0; i < 300; i++) begin
            int unsigned  sel;
            logic [W-1:0] nxt;
            sel = $urandom_range(0, 19);
            if (sel == 0) begin
                arst_n = 1'b1;
                m_pc   = RVAL;
                #1 check_state("rnd_rst");
                #1 arst_n = 1'b0;
            end else begin
                nxt = (sel == 1) ? 32'hFFFF_FFFF : $urandom;
                edge_step($urandom_range(0, 3) != 0, nxt, "rnd");
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pc.md
PC -- requirements
Module: pc

Interface
Parameters (name, default, meaning):
REQ-001 The block SHALL have parameter PC_SIZE, default 32, giving the program-counter width in bits.
REQ-002 The block SHALL have parameter RESET_VAL, default 0 (PC_SIZE bits wide), giving the value loaded on reset.

Ports (name, direction, width, meaning):
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock; all state updates occur on its rising edge.
REQ-004 The block SHALL have port arst_n, input, 1 bit, asynchronous active-high reset; the name is kept for codebase consistency, and logic 1 asserts reset.
REQ-005 The block SHALL have port en_in, input, 1 bit, load enable; 0 means stall and hold the current value.
REQ-006 The block SHALL have port pc_in, input, PC_SIZE bits, the next PC value (PC+4 or branch target, chosen upstream).
REQ-007 The block SHALL have port pc_out, output, PC_SIZE bits, the current PC, driven directly from a register.
REQ-008 The block SHALL have port misalign_out, output, 1 bit, high when pc_out[1:0] != 2'b00.

Function
REQ-009 pc_out SHALL be a PC_SIZE-bit register with no combinational path from pc_in or en_in to pc_out.
REQ-010 On a rising clk edge with reset deasserted and en_in=1, pc_out SHALL take the value of pc_in sampled at that edge: latency 1 cycle, no alignment masking, no arithmetic.
REQ-011 On a rising clk edge with reset deasserted and en_in=0, pc_out SHALL hold its previous value; stalls of any length SHALL be supported.
REQ-012 pc_in SHALL be loaded verbatim at full width: no wrap logic, no saturation, and a value of all-ones SHALL be stored unchanged.
REQ-013 misalign_out SHALL be purely combinational from pc_out and SHALL never alter the register contents.
REQ-014 Changes on pc_in or en_in between clock edges SHALL have no effect on pc_out.
REQ-015 X or Z on en_in while out of reset SHALL NOT be masked; simulation assertion failure is acceptable.

Reset
REQ-016 Asserting arst_n (logic 1) SHALL set pc_out to RESET_VAL immediately, without waiting for a clock edge, and misalign_out to |RESET_VAL[1:0] (0 at the default).
REQ-017 While reset is asserted, pc_out SHALL remain RESET_VAL regardless of clk, en_in and pc_in.
REQ-018 On the first rising clk edge after reset deassertion, normal operation per REQ-010/REQ-011 SHALL resume; the value first fetched is RESET_VAL.
REQ-019 Reset asserted mid-stream, including during a stall or coincident with a clock edge, SHALL win over any load.

Verification
REQ-020 Reset with arst_n=1 while pc_out=0x0000_0040, no clk edge -> pc_out=0x0000_0000 immediately; misalign_out=0.
REQ-021 Release reset, en_in=1, pc_in=pc_out+4 each cycle for 4 cycles -> pc_out sequence 0x0, 0x4, 0x8, 0xC, 0x10.
REQ-022 pc_out=0x10, en_in=0 for 3 cycles with pc_in=0x14 -> pc_out stays 0x10; then en_in=1 -> 0x14 after one edge.
REQ-023 Branch case: pc_out=0x14, pc_in=0x100 with en_in=1 -> pc_out=0x100 next edge; then pc_in=0x0000_0002 -> pc_out=0x2 and misalign_out=1.
REQ-024 Boundary case: pc_in=0xFFFF_FFFC loaded, then pc_in=0x0000_0000 (wrapped PC+4) -> pc_out=0xFFFF_FFFC, then 0x0000_0000.
REQ-025 Reset asserted on the same edge as en_in=1 with pc_in=0x80 -> pc_out=0x0.
